// File: rtl/regfile_pkg.sv
// Shared constants and requester IDs for the register-file read-port arbiter.
package regfile_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned NREGS = 8;

    typedef enum logic [1:0] {
        RQ_OPA = 2'd0,
        RQ_OPB = 2'd1,
        RQ_BR  = 2'd2,
        RQ_DBG = 2'd3
    } rq_id_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of eligible searching upward from ptr+1, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] win
);

    localparam int unsigned SW = ID_W + 1;

    logic [SW-1:0]     base;
    logic [2*NREQ-1:0] ext;
    logic [NREQ-1:0]   rot;
    logic [SW-1:0]     enc;
    logic [SW:0]       sum;

    // Rotate so ptr+1 sits at bit 0, priority-encode the lowest bit, then un-rotate.
    always_comb begin
        base  = SW'(ptr) + SW'(1);
        ext   = {eligible, eligible} >> base;
        rot   = ext[NREQ-1:0];
        found = |rot;
        enc   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) enc = SW'(i);
        end
        sum = (SW+1)'(base) + (SW+1)'(enc);
        if (sum >= (SW+1)'(NREQ)) sum = sum - (SW+1)'(NREQ);
        win = ID_W'(sum);
    end

endmodule

// File: rtl/regfile_rd_arbiter.sv
// Round-robin arbiter sharing the single register-file read port; 2-stage pipeline
// (grant + index, then tagged response capture).
module regfile_rd_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [IDX_W*NREQ-1:0] req_idx,
    input  logic                  stall,
    output logic [NREQ-1:0]       gnt,
    output logic [IDX_W-1:0]      reg_idx,
    input  logic [DAT_W-1:0]      reg_dat,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DAT_W-1:0]      rsp_data
);

    logic [NREQ-1:0]  gnt_q,       gnt_d;
    logic [IDX_W-1:0] reg_idx_q,   reg_idx_d;
    logic [ID_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]  s1_id_q,     s1_id_d;
    logic             s1_vld_q,    s1_vld_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
    logic [DAT_W-1:0] rsp_data_q,  rsp_data_d;

    logic [NREQ-1:0]  eligible_c;
    logic             found_c;
    logic [ID_W-1:0]  win_c;
    logic [IDX_W-1:0] win_idx_c;

    // A requester granted this cycle is masked so it cannot win twice back to back.
    assign eligible_c = req & ~gnt_q;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .eligible (eligible_c),
        .ptr      (rr_ptr_q),
        .found    (found_c),
        .win      (win_c)
    );

    // Select the winning requester's register index from the packed index bus.
    always_comb begin
        win_idx_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == win_c) win_idx_c = req_idx[IDX_W*i +: IDX_W];
        end
    end

    // Next-state: stage 0 arbitration and stage 1 response capture.
    always_comb begin
        gnt_d       = '0;
        s1_vld_d    = 1'b0;
        s1_id_d     = s1_id_q;
        reg_idx_d   = reg_idx_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = s1_vld_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        if (!stall && found_c) begin
            gnt_d     = NREQ'(1) << win_c;
            reg_idx_d = win_idx_c;
            s1_id_d   = win_c;
            s1_vld_d  = 1'b1;
            rr_ptr_d  = win_c;
        end

        if (s1_vld_q) begin
            rsp_id_d   = s1_id_q;
            rsp_data_d = reg_dat;
        end
    end

    // Pipeline registers; reset drops any in-flight grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            reg_idx_q   <= '0;
            rr_ptr_q    <= ID_W'(NREQ - 1);
            s1_id_q     <= '0;
            s1_vld_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            gnt_q       <= gnt_d;
            reg_idx_q   <= reg_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            s1_id_q     <= s1_id_d;
            s1_vld_q    <= s1_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign reg_idx   = reg_idx_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
